seq_detector_p: RTL and testbench

Parametrised serial bit-pattern detector. It generalises the fixed two-state "1 then 0" recogniser to a runtime-programmable pattern of 1..PAT_W bits. It adds valid-qualified input, overlapping, non-overlapping and one-shot modes, and a saturating match counter. It sits on a serial input stream and produces a registered match pulse for downstream control logic.

---
 rtl/seq_detector_p.sv | 110 +++++++++++
 tb/tb_seq_detector_p.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_p.sv
// seq_detector_p: programmable serial pattern detector with overlap, non-overlap
// and one-shot modes, valid-qualified input and a saturating match counter.
module seq_detector_p #(
  parameter int PAT_W = 8,
  parameter int COUNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               enable,
  input  logic               cfg_we,
  input  logic [PAT_W-1:0]   cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [1:0]         cfg_mode,
  input  logic               rearm,
  input  logic               clr_count,
  output logic               match,
  output logic [COUNT_W-1:0] match_count,
  output logic               sat,
  output logic [1:0]         state
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, HOLD = 2'd2} state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, cand, mask;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d, len_c, fill_inc;
  logic [1:0] mode_q, mode_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic match_q, sat_q, sat_d, accept, hit;
  always_comb begin
    len_c = cfg_len == '0 ? LEN_W'(1) : cfg_len > LEN_W'(PAT_W) ? LEN_W'(PAT_W) : cfg_len;
    cand = {hist_q[PAT_W-2:0], in};
    mask = ~({PAT_W{1'b1}} << len_q);
    fill_inc = fill_q == LEN_W'(PAT_W) ? fill_q : fill_q + LEN_W'(1);
    accept = state_q == SEARCH && in_valid;
    hit = accept && ({1'b0, fill_q} + (LEN_W+1)'(1) >= {1'b0, len_q}) && ((cand ^ pat_q) & mask) == '0;
  end
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    len_d = len_q;
    mode_d = mode_q;
    hist_d = hist_q;
    fill_d = fill_q;
    case (state_q)
      IDLE: begin
        hist_d = '0;
        fill_d = '0;
        if (cfg_we) begin
          pat_d = cfg_pattern;
          len_d = len_c;
          mode_d = cfg_mode;
        end
        if (enable) state_d = SEARCH;
      end
      SEARCH: begin
        if (!enable) begin
          state_d = IDLE;
          hist_d = '0;
          fill_d = '0;
        end else if (accept) begin
          hist_d = cand;
          // non-overlap restarts the fill so the next hit needs len fresh bits
          fill_d = hit && mode_q == 2'd1 ? '0 : fill_inc;
          if (hit && mode_q == 2'd2) state_d = HOLD;
        end
      end
      HOLD: begin
        if (!enable || rearm) begin
          state_d = enable ? SEARCH : IDLE;
          hist_d = '0;
          fill_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d = clr_count ? (hit ? COUNT_W'(1) : '0) : hit && !(&cnt_q) ? cnt_q + COUNT_W'(1) : cnt_q;
    sat_d = !clr_count && (sat_q || &cnt_d);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q <= '0;
      len_q <= LEN_W'(1);
      mode_q <= '0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      mode_q <= mode_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      match_q <= hit;
    end
  end
  assign match = match_q;
  assign match_count = cnt_q;
  assign sat = sat_q;
  assign state = state_q;
endmodule

// File: tb/tb_seq_detector_p.sv
// tb_seq_detector_p: directed and random stimulus against a queue-based reference model.
module tb_seq_detector_p;
  localparam int PAT_W = 8;
  localparam int COUNT_W = 2;
  localparam int LEN_W = 4;
  localparam int CMAX = (1 << COUNT_W) - 1;
  logic clk = 1'b0;
  logic reset, in, in_valid, enable, cfg_we, rearm, clr_count;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [1:0] cfg_mode;
  logic match, sat;
  logic [COUNT_W-1:0] match_count;
  logic [1:0] state;
  int n_cmp = 0, n_err = 0;
  int m_state, m_len, m_mode, m_cnt;
  logic [PAT_W-1:0] m_pat;
  bit m_sat, m_match;
  bit q[$];
  always #5 clk = ~clk;
  seq_detector_p #(.PAT_W(PAT_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .enable(enable),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .rearm(rearm), .clr_count(clr_count), .match(match), .match_count(match_count),
    .sat(sat), .state(state)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0; m_pat = '0; m_len = 1; m_mode = 0;
    m_cnt = 0; m_sat = 0; m_match = 0;
    q.delete();
  endtask
  task automatic check_all(string tag);
    check({tag, ".match"}, match, m_match);
    check({tag, ".count"}, match_count, m_cnt);
    check({tag, ".sat"}, sat, m_sat);
    check({tag, ".state"}, state, m_state);
  endtask
  // The model keeps the accepted bits since the last clear and compares the newest len of them.
  task automatic tick(string tag);
    bit hit = 0;
    int l;
    case (m_state)
      0: begin
        q.delete();
        if (cfg_we) begin
          l = int'(cfg_len);
          m_len = l == 0 ? 1 : l > PAT_W ? PAT_W : l;
          m_pat = cfg_pattern;
          m_mode = int'(cfg_mode);
        end
        if (enable) m_state = 1;
      end
      1: begin
        if (in_valid) begin
          q.push_back(in);
          if (q.size() > PAT_W) void'(q.pop_front());
          if (q.size() >= m_len) begin
            hit = 1;
            for (int i = 0; i < m_len; i++) if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
          end
          if (hit && m_mode == 1) q.delete();
          if (hit && m_mode == 2) m_state = 2;
        end
        if (!enable) begin m_state = 0; q.delete(); end
      end
      default: begin
        if (!enable) begin m_state = 0; q.delete(); end
        else if (rearm) begin m_state = 1; q.delete(); end
      end
    endcase
    if (clr_count) begin
      m_cnt = hit ? 1 : 0;
      m_sat = 0;
    end else if (hit) begin
      if (m_cnt < CMAX) m_cnt++;
      if (m_cnt == CMAX) m_sat = 1;
    end
    m_match = hit;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  task automatic quiet();
    in = 0; in_valid = 0; cfg_we = 0; rearm = 0; clr_count = 0;
  endtask
  task automatic configure(logic [PAT_W-1:0] p, logic [LEN_W-1:0] l, logic [1:0] md);
    quiet();
    enable = 0;
    tick("idle");
    cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_mode = md; clr_count = 1;
    tick("cfg");
    quiet();
    enable = 1;
    tick("en");
  endtask
  task automatic send(bit b);
    in = b; in_valid = 1;
    tick("bit");
    in_valid = 0;
  endtask
  initial begin
    quiet();
    reset = 1; enable = 0; cfg_pattern = '0; cfg_len = '0; cfg_mode = '0;
    model_reset();
    #1 check_all("reset");
    @(posedge clk); #1 reset = 0;
    configure(8'b10, 4'd2, 2'd0);
    send(1); send(0); check("legacy_m2", match, 1);
    send(1); send(1); send(0); check("legacy_m5", match, 1);
    check("legacy_cnt", match_count, 2);
    configure(8'b1011, 4'd4, 2'd0);
    foreach (q[i]) ;
    send(1); send(0); send(1); send(1); check("ovl_m4", match, 1);
    send(0); send(1); send(1); check("ovl_m7", match, 1);
    check("ovl_cnt", match_count, 2);
    configure(8'b1011, 4'd4, 2'd1);
    send(1); send(0); send(1); send(1); send(0); send(1); send(1);
    check("novl_m7", match, 0);
    check("novl_cnt", match_count, 1);
    configure(8'b111, 4'd3, 2'd2);
    repeat (5) send(1);
    check("os_state", state, 2);
    check("os_cnt", match_count, 1);
    rearm = 1; tick("rearm"); rearm = 0;
    send(1); send(1); send(1);
    check("os_rearm_m", match, 1);
    check("os_rearm_cnt", match_count, 2);
    configure(8'b10, 4'd2, 2'd0);
    send(1);
    in = 0; in_valid = 0; tick("gap");
    send(0);
    check("gap_cnt", match_count, 1);
    cfg_we = 1; cfg_pattern = 8'b01; cfg_len = 4'd2; tick("lockout"); cfg_we = 0;
    send(1); send(0);
    check("lockout_cnt", match_count, 2);
    configure(8'b1, 4'd1, 2'd1);
    repeat (5) send(1);
    check("sat_cnt", match_count, 3);
    check("sat_flag", sat, 1);
    clr_count = 1; send(1); clr_count = 0;
    check("clrhit_cnt", match_count, 1);
    check("clrhit_sat", sat, 0);
    configure(8'b11, 4'd2, 2'd0);
    send(1); send(1);
    #2 reset = 1;
    model_reset();
    #1 check_all("async");
    #2 reset = 0;
    configure(8'b10, 4'd2, 2'd0);
    send(0);
    check("post_reset_m", match, 0);
    repeat (40) begin
      configure(PAT_W'($urandom), LEN_W'($urandom_range(0, 5) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 4)), 2'($urandom));
      repeat (60) begin
        in = 1'($urandom);
        in_valid = $urandom_range(0, 3) != 0;
        enable = $urandom_range(0, 30) != 0;
        rearm = $urandom_range(0, 7) == 0;
        clr_count = $urandom_range(0, 40) == 0;
        cfg_we = $urandom_range(0, 9) == 0;
        cfg_pattern = PAT_W'($urandom);
        cfg_len = LEN_W'($urandom);
        cfg_mode = 2'($urandom);
        tick("rnd");
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
